cam_dvp_pattern_gen: RTL and testbench

//  Synthesisable, parametrised DVP camera source (OV7670-style PCLK/VSYNC/HREF/DATA).

---
 rtl/cam_pkg.sv | 24 ++
 rtl/cam_pclk_div.sv | 31 +++
 rtl/cam_dvp_pattern_gen.sv | 161 ++++++++++++++++
 tb/tb_cam_dvp_pattern_gen.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_pkg.sv
// Shared types and helpers for the DVP camera pattern source.
package cam_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_VSYNC  = 3'd1,
    ST_VBACK  = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_VFRONT = 3'd4
  } cam_state_e;

  typedef enum logic [1:0] {
    PAT_CONST   = 2'd0,
    PAT_HRAMP   = 2'd1,
    PAT_VBARS   = 2'd2,
    PAT_CHECKER = 2'd3
  } cam_pattern_e;

  // Takes only gray[7:2]; the two LSBs never reach any RGB565 channel.
  function automatic logic [15:0] gray_to_rgb565(input logic [7:2] gray_hi);
    return {gray_hi[7:3], gray_hi[7:2], gray_hi[7:3]};
  endfunction

endpackage

// File: rtl/cam_pclk_div.sv
// Free-running PCLK divider with a strobe on the board cycle where PCLK falls.
module cam_pclk_div #(
  parameter int unsigned PCLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  output logic pclk,
  output logic fall_stb
);

  localparam int unsigned CNT_W = (PCLK_DIV > 1) ? $clog2(PCLK_DIV) : 1;

  logic [CNT_W-1:0] cnt_q;
  logic             tick;

  assign tick     = (32'(cnt_q) == PCLK_DIV - 1);
  assign fall_stb = tick & pclk;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      pclk  <= 1'b0;
    end else if (tick) begin
      cnt_q <= '0;
      pclk  <= ~pclk;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/cam_dvp_pattern_gen.sv
// DVP camera source: full frames with blanking and selectable test patterns.
module cam_dvp_pattern_gen
  import cam_pkg::*;
#(
  parameter int unsigned ACT_W     = 640,
  parameter int unsigned ACT_H     = 480,
  parameter int unsigned BPP       = 2,
  parameter int unsigned H_BLANK   = 144,
  parameter int unsigned VS_LINES  = 3,
  parameter int unsigned V_BACK    = 17,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned PCLK_DIV  = 2,
  parameter logic [7:0]  CONST_VAL = 8'd8
) (
  input  logic        i_board_clk,
  input  logic        i_rst,
  input  logic        i_enable,
  input  logic [1:0]  i_pattern,
  output logic        o_cam_pclk,
  output logic        o_cam_vsync,
  output logic        o_cam_href,
  output logic [7:0]  o_cam_data,
  output logic        o_frame_done,
  output logic [15:0] o_frame_cnt
);

  localparam int unsigned ACT_BYTES = ACT_W * BPP;
  localparam int unsigned LINE      = ACT_BYTES + H_BLANK;
  localparam int unsigned COL_W     = (LINE > 1) ? $clog2(LINE) : 1;
  localparam int unsigned ROW_W     = 16;

  // Zero-length phases are skipped; ST_IDLE here marks "frame finished".
  localparam cam_state_e AFTER_ACT = (V_FRONT > 0) ? ST_VFRONT : ST_IDLE;
  localparam cam_state_e AFTER_VB  = (ACT_H > 0)   ? ST_ACTIVE : AFTER_ACT;
  localparam cam_state_e AFTER_VS  = (V_BACK > 0)  ? ST_VBACK  : AFTER_VB;
  localparam cam_state_e FIRST_ST  = (VS_LINES > 0) ? ST_VSYNC : AFTER_VS;

  function automatic int unsigned state_len(input cam_state_e s);
    case (s)
      ST_VSYNC:  return VS_LINES;
      ST_VBACK:  return V_BACK;
      ST_ACTIVE: return ACT_H;
      ST_VFRONT: return V_FRONT;
      default:   return 1;
    endcase
  endfunction

  function automatic cam_state_e next_run(input cam_state_e s);
    case (s)
      ST_VSYNC:  return AFTER_VS;
      ST_VBACK:  return AFTER_VB;
      ST_ACTIVE: return AFTER_ACT;
      default:   return ST_IDLE;
    endcase
  endfunction

  logic fall_stb;

  cam_pclk_div #(
    .PCLK_DIV (PCLK_DIV)
  ) u_pclk_div (
    .clk      (i_board_clk),
    .rst      (i_rst),
    .pclk     (o_cam_pclk),
    .fall_stb (fall_stb)
  );

  cam_state_e       state_q, state_d;
  cam_pattern_e     pat_q, pat_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic             frame_end, frame_start;

  logic [8:0]  col_ext;
  logic [7:0]  x8;
  logic [7:0]  pix;
  logic [15:0] rgb;
  logic [7:0]  pix_byte;
  logic        vsync_d, href_d;
  logic [7:0]  data_d;

  // Next-state: timing advances one PCLK period per falling strobe.
  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    pat_d       = pat_q;
    frame_end   = 1'b0;
    frame_start = 1'b0;
    if (state_q == ST_IDLE) begin
      if (i_enable) begin
        state_d     = FIRST_ST;
        frame_start = 1'b1;
      end
    end else if (col_q == COL_W'(LINE - 1)) begin
      col_d = '0;
      if (32'(row_q) == state_len(state_q) - 1) begin
        row_d   = '0;
        state_d = next_run(state_q);
        if (state_d == ST_IDLE) begin
          frame_end = 1'b1;
          if (i_enable) begin
            state_d     = FIRST_ST;
            frame_start = 1'b1;
          end
        end
      end else begin
        row_d = row_q + ROW_W'(1);
      end
    end else begin
      col_d = col_q + COL_W'(1);
    end
    if (frame_start) pat_d = cam_pattern_e'(i_pattern);
  end

  // Outputs decoded from the next timing position so they register together.
  always_comb begin
    col_ext = 9'(col_d);
    x8      = (BPP == 2) ? col_ext[8:1] : col_ext[7:0];
    case (pat_d)
      PAT_CONST: pix = CONST_VAL;
      PAT_HRAMP: pix = x8;
      PAT_VBARS: pix = x8[5] ? 8'hFF : 8'h00;
      default:   pix = (x8[4] ^ row_d[4]) ? 8'hFF : 8'h00;
    endcase
    rgb = gray_to_rgb565(pix[7:2]);
    if (BPP == 2) pix_byte = col_d[0] ? rgb[7:0] : rgb[15:8];
    else          pix_byte = pix;
    vsync_d = (state_d == ST_VSYNC);
    href_d  = (state_d == ST_ACTIVE) && (32'(col_d) < ACT_BYTES);
    data_d  = href_d ? pix_byte : 8'h00;
  end

  // Register stage: everything except the done pulse moves on the PCLK fall.
  always_ff @(posedge i_board_clk) begin
    if (i_rst) begin
      state_q      <= ST_IDLE;
      pat_q        <= PAT_CONST;
      col_q        <= '0;
      row_q        <= '0;
      o_cam_vsync  <= 1'b0;
      o_cam_href   <= 1'b0;
      o_cam_data   <= 8'h00;
      o_frame_done <= 1'b0;
      o_frame_cnt  <= 16'h0000;
    end else begin
      o_frame_done <= fall_stb & frame_end;
      if (fall_stb) begin
        state_q     <= state_d;
        pat_q       <= pat_d;
        col_q       <= col_d;
        row_q       <= row_d;
        o_cam_vsync <= vsync_d;
        o_cam_href  <= href_d;
        o_cam_data  <= data_d;
        if (frame_end) o_frame_cnt <= o_frame_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_cam_dvp_pattern_gen.sv
// Scoreboard bench for cam_dvp_pattern_gen over four small parameter sets.
module tb_cam_dvp_pattern_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic [1:0] pat = 2'd0;
  int         sel = 0;

  always #5 clk = ~clk;

  logic        pclk_w [4];
  logic        vs_w   [4];
  logic        href_w [4];
  logic        done_w [4];
  logic [7:0]  data_w [4];
  logic [15:0] cnt_w  [4];

  cam_dvp_pattern_gen #(.ACT_W(4), .ACT_H(3), .BPP(1), .H_BLANK(2), .VS_LINES(1),
    .V_BACK(1), .V_FRONT(1), .PCLK_DIV(1), .CONST_VAL(8'h08)) u_b1 (
    .i_board_clk(clk), .i_rst(rst), .i_enable(en), .i_pattern(pat),
    .o_cam_pclk(pclk_w[0]), .o_cam_vsync(vs_w[0]), .o_cam_href(href_w[0]),
    .o_cam_data(data_w[0]), .o_frame_done(done_w[0]), .o_frame_cnt(cnt_w[0]));

  cam_dvp_pattern_gen #(.ACT_W(4), .ACT_H(3), .BPP(2), .H_BLANK(2), .VS_LINES(1),
    .V_BACK(1), .V_FRONT(1), .PCLK_DIV(1), .CONST_VAL(8'h80)) u_b2 (
    .i_board_clk(clk), .i_rst(rst), .i_enable(en), .i_pattern(pat),
    .o_cam_pclk(pclk_w[1]), .o_cam_vsync(vs_w[1]), .o_cam_href(href_w[1]),
    .o_cam_data(data_w[1]), .o_frame_done(done_w[1]), .o_frame_cnt(cnt_w[1]));

  cam_dvp_pattern_gen #(.ACT_W(4), .ACT_H(3), .BPP(2), .H_BLANK(2), .VS_LINES(1),
    .V_BACK(1), .V_FRONT(1), .PCLK_DIV(1), .CONST_VAL(8'hFF)) u_b2f (
    .i_board_clk(clk), .i_rst(rst), .i_enable(en), .i_pattern(pat),
    .o_cam_pclk(pclk_w[2]), .o_cam_vsync(vs_w[2]), .o_cam_href(href_w[2]),
    .o_cam_data(data_w[2]), .o_frame_done(done_w[2]), .o_frame_cnt(cnt_w[2]));

  cam_dvp_pattern_gen #(.ACT_W(64), .ACT_H(3), .BPP(1), .H_BLANK(2), .VS_LINES(1),
    .V_BACK(1), .V_FRONT(1), .PCLK_DIV(1), .CONST_VAL(8'h08)) u_w64 (
    .i_board_clk(clk), .i_rst(rst), .i_enable(en), .i_pattern(pat),
    .o_cam_pclk(pclk_w[3]), .o_cam_vsync(vs_w[3]), .o_cam_href(href_w[3]),
    .o_cam_data(data_w[3]), .o_frame_done(done_w[3]), .o_frame_cnt(cnt_w[3]));

  logic        m_pclk, m_vs, m_href, m_done;
  logic [7:0]  m_data;
  logic [15:0] m_cnt;

  always_comb begin
    m_pclk = pclk_w[sel];
    m_vs   = vs_w[sel];
    m_href = href_w[sel];
    m_done = done_w[sel];
    m_data = data_w[sel];
    m_cnt  = cnt_w[sel];
  end

  logic [7:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int href_rises = 0;
  int vs_pclks = 0;
  int done_pulses = 0;
  logic pclk_prev = 1'b0;
  logic href_prev = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Receiver model: sample on each rising PCLK, as a DVP capture block would.
  always @(negedge clk) begin
    if (rst) begin
      pclk_prev = 1'b0;
      href_prev = 1'b0;
    end else begin
      if (m_done) done_pulses++;
      if (m_pclk && !pclk_prev) begin
        if (m_vs) vs_pclks++;
        if (m_href && !href_prev) href_rises++;
        if (m_href) begin
          check_eq("sb_has_entry", 32'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) check_eq("pixel_byte", m_data, exp_q.pop_front());
        end else begin
          check_eq("data_zero_outside_href", m_data, 0);
        end
        href_prev = m_href;
      end
      pclk_prev = m_pclk;
    end
  end

  task automatic do_reset(input int s);
    @(negedge clk);
    rst = 1'b1;
    en  = 1'b0;
    sel = s;
    repeat (3) @(negedge clk);
    check_eq("reset_outputs", {m_pclk, m_vs, m_href, m_done, m_data, m_cnt}, 0);
    exp_q.delete();
    href_rises  = 0;
    vs_pclks    = 0;
    done_pulses = 0;
    rst = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    @(negedge clk);
    while (!m_done && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, 32'(m_done), 1);
  endtask

  task automatic wait_href(input int k, input string tag);
    int n = 0;
    while (href_rises < k && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, 32'(href_rises >= k), 1);
  endtask

  task automatic push_rep(input logic [7:0] v, input int count);
    for (int i = 0; i < count; i++) exp_q.push_back(v);
  endtask

  initial begin
    int n;

    // Constant gray, two back-to-back frames then stop.
    do_reset(0);
    pat = 2'd0;
    push_rep(8'h08, 24);
    en = 1'b1;
    wait_done("t1_done1");
    check_eq("t1_cnt1", m_cnt, 1);
    en = 1'b0;
    wait_done("t1_done2");
    check_eq("t1_cnt2", m_cnt, 2);
    repeat (100) @(negedge clk);
    check_eq("t1_href_pulses", href_rises, 6);
    check_eq("t1_vsync_pclks", vs_pclks, 12);
    check_eq("t1_done_pulses", done_pulses, 2);
    check_eq("t1_sb_empty", exp_q.size(), 0);

    // Horizontal ramp at one byte per pixel.
    do_reset(0);
    pat = 2'd1;
    for (int l = 0; l < 3; l++)
      for (int x = 0; x < 4; x++) exp_q.push_back(8'(x));
    en = 1'b1;
    wait_href(1, "t2_href_seen");
    en = 1'b0;
    wait_done("t2_done");
    check_eq("t2_cnt", m_cnt, 1);
    check_eq("t2_sb_empty", exp_q.size(), 0);

    // RGB565 of gray 0x80 and 0xFF.
    do_reset(1);
    pat = 2'd0;
    for (int i = 0; i < 12; i++) begin
      exp_q.push_back(8'h84);
      exp_q.push_back(8'h10);
    end
    en = 1'b1;
    wait_href(1, "t3a_href_seen");
    en = 1'b0;
    wait_done("t3a_done");
    check_eq("t3a_href_pulses", href_rises, 3);
    check_eq("t3a_sb_empty", exp_q.size(), 0);

    do_reset(2);
    pat = 2'd0;
    push_rep(8'hFF, 24);
    en = 1'b1;
    wait_href(1, "t3b_href_seen");
    en = 1'b0;
    wait_done("t3b_done");
    check_eq("t3b_sb_empty", exp_q.size(), 0);

    // Enable dropped during active line 1: frame finishes, then silence.
    do_reset(0);
    pat = 2'd0;
    push_rep(8'h08, 12);
    en = 1'b1;
    wait_href(2, "t4_line1");
    en = 1'b0;
    wait_done("t4_done");
    check_eq("t4_cnt", m_cnt, 1);
    repeat (150) @(negedge clk);
    check_eq("t4_done_pulses", done_pulses, 1);
    check_eq("t4_href_pulses", href_rises, 3);
    check_eq("t4_vsync_pclks", vs_pclks, 6);
    check_eq("t4_idle_lines", {m_vs, m_href}, 0);
    check_eq("t4_sb_empty", exp_q.size(), 0);

    // Mid-frame pattern change applies from the next frame.
    do_reset(3);
    pat = 2'd0;
    push_rep(8'h08, 192);
    for (int l = 0; l < 3; l++)
      for (int x = 0; x < 64; x++) exp_q.push_back((x < 32) ? 8'h00 : 8'hFF);
    en = 1'b1;
    wait_href(1, "t5_href_seen");
    pat = 2'd2;
    wait_done("t5_done1");
    en = 1'b0;
    wait_done("t5_done2");
    check_eq("t5_cnt", m_cnt, 2);
    check_eq("t5_href_pulses", href_rises, 6);
    check_eq("t5_sb_empty", exp_q.size(), 0);

    // Reset in the middle of an active line.
    do_reset(0);
    pat = 2'd0;
    push_rep(8'h08, 24);
    en = 1'b1;
    wait_done("t6_done1");
    wait_href(4, "t6_frame2_active");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("t6_rst_outputs", {m_pclk, m_vs, m_href, m_done, m_data, m_cnt}, 0);
    exp_q.delete();
    href_rises  = 0;
    vs_pclks    = 0;
    done_pulses = 0;
    rst = 1'b0;
    n = 0;
    while (!m_vs && n < 10) begin
      @(negedge clk);
      n++;
    end
    check_eq("t6_vsync_latency", n, 2);
    check_eq("t6_pclk_low_at_vsync", 32'(m_pclk), 0);
    push_rep(8'h08, 12);
    en = 1'b0;
    wait_done("t6_done_after_rst");
    check_eq("t6_cnt_restart", m_cnt, 1);
    check_eq("t6_sb_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
